hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Central sequencer for pipeline freeze, bubble and flush.
- Watches ID-stage source registers against EXE/MEM destinations, the EXE branch decision, and the MEM-stage SRAM handshake.
- Drives the IF/ID hold, the ID-stage control-mux Freeze (bubble insert), the branch flushes and the global memory-wait freeze.
- Keeps a stall-cycle performance counter and flags a memory-wait timeout.

Parameters:
- FORWARD_EN, 1, 1 = forwarding unit present, only load-use stalls; 0 = any RAW against EXE/MEM stalls.
- MEM_TIMEOUT, 255, maximum consecutive MEM_WAIT cycles before mem_timeout is raised (1..65535).
- CNT_WIDTH, 16, width of stall_cycles counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- id_has_src1  in  1  ID instruction reads src1.
- id_has_src2  in  1  ID instruction reads src2.
- id_src1  in  4  ID src1 register index.
- id_src2  in  4  ID src2 register index (post store-mux).
- exe_wb_en  in  1  EXE instruction writes back.
- exe_dst  in  4  EXE destination.
- exe_mem_read  in  1  EXE instruction is a load.
- mem_wb_en  in  1  MEM instruction writes back.
- mem_dst  in  4  MEM destination.
- branch_taken  in  1  EXE branch resolved taken.
- mem_req  in  1  MEM stage issuing SRAM read/write this cycle.
- sram_ready  in  1  SRAM completes access this cycle.
- freeze_pc  out  1  hold PC.
- freeze_if_id  out  1  hold IF/ID register.
- bubble_id  out  1  drive ID Freeze: zero control bits into ID/EX.
- flush_if_id  out  1  clear IF/ID.
- flush_id_ex  out  1  clear ID/EX.
- freeze_all  out  1  hold every pipeline register (memory wait).
- mem_timeout  out  1  one-cycle pulse on timeout.
- stall_cycles  out  CNT_WIDTH  saturating count of cycles with any freeze/bubble.

Behaviour:
- Reset: while rst=0 at a clk edge, state<=RUN, wait_cnt<=0, stall_cycles<=0. All combinational outputs are forced to 0 while rst=0.
- States: RUN, MEM_WAIT.
- Hazard term hz:
  - src1 match = id_has_src1 & (id_src1 == dst); src2 likewise.
  - FORWARD_EN=1: hz = exe_wb_en & exe_mem_read & match(exe_dst).
  - FORWARD_EN=0: hz = (exe_wb_en & match(exe_dst)) | (mem_wb_en & match(mem_dst)).
- RUN, priority order (evaluated combinationally, same cycle):
  1. mem_req & ~sram_ready: freeze_all=1, all else 0; next MEM_WAIT, wait_cnt<=1.
  2. branch_taken: flush_if_id=1, flush_id_ex=1; hz ignored (instruction is being flushed).
  3. hz: freeze_pc=1, freeze_if_id=1, bubble_id=1.
  4. Otherwise all 0.
- MEM_WAIT:
  - sram_ready=0: freeze_all=1, wait_cnt increments.
  - If wait_cnt == MEM_TIMEOUT: mem_timeout=1 for that cycle, freeze_all=0, wait_cnt<=0, next RUN (access abandoned).
  - sram_ready=1: freeze_all=0. In the same cycle, RUN rules 2-3 apply (branch/hazard held stable during the freeze are acted on now). Next RUN, wait_cnt<=0.
- mem_req & sram_ready in the same RUN cycle: zero-wait access, no freeze.
- stall_cycles increments on every cycle where freeze_all|bubble_id. It saturates at all-ones. Flush cycles are not counted.
- freeze_all=1 implies freeze_pc/freeze_if_id/bubble_id/flush_* = 0; pipeline registers interpret freeze_all alone.
- Reset mid-MEM_WAIT: returns to RUN next edge, no mem_timeout pulse.

Decomposition:
- Shared constants header: REG_FILE_DEPTH (4), state encodings RUN/MEM_WAIT, default MEM_TIMEOUT.
- One natural sub-module: raw_hazard_detect (combinational hz from sources/destinations and FORWARD_EN).
- FSM, timeout counter and perf counter stay in the top.

Test Plan:
- FORWARD_EN=1: EXE LDR R3 (exe_mem_read=1, exe_dst=3), ID ADD src1=3 has_src1=1 -> bubble_id=freeze_pc=freeze_if_id=1 for exactly 1 cycle; stall_cycles=1. Same with exe_mem_read=0 -> no stall.
- FORWARD_EN=0: mem_wb_en=1 mem_dst=5, id_src2=5 has_src2=1 -> bubble 1 cycle. has_src2=0 -> no bubble.
- branch_taken=1 with simultaneous load-use hz -> flush_if_id=flush_id_ex=1, bubble_id=0, stall_cycles unchanged.
- mem_req=1, sram_ready low 4 cycles then high -> freeze_all=1 for 4 cycles, 0 on the ready cycle; stall_cycles=4; state back to RUN.
- MEM_TIMEOUT=3, sram_ready never rises -> freeze_all 1 for cycles 1-2, cycle 3 mem_timeout=1 pulse, freeze_all=0, state RUN.
- rst=0 asserted during MEM_WAIT -> outputs 0 immediately, stall_cycles=0 after the edge, no timeout pulse. Preload to all-ones and stall -> stall_cycles holds all-ones.

Source files
------------

// File: rtl/hazard_stall_controller_pkg.sv
// Shared constants for the hazard/stall sequencer.
//   REG_FILE_DEPTH      : width in bits of a register index (16-entry file)
//   DEFAULT_MEM_TIMEOUT : default limit on consecutive memory-wait cycles
//   state_t             : sequencer states
package hazard_stall_controller_pkg;

  localparam int REG_FILE_DEPTH      = 4;
  localparam int DEFAULT_MEM_TIMEOUT = 255;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Bundle of pipeline status inputs and stall/flush controls.
//   master : pipeline side, drives ID/EXE/MEM status and SRAM handshake
//   slave  : sequencer side, drives freeze/bubble/flush, timeout and counter
interface hazard_stall_controller_if #(
  parameter int CNT_WIDTH = 16
) ();
  import hazard_stall_controller_pkg::*;

  logic                      id_has_src1;
  logic                      id_has_src2;
  logic [REG_FILE_DEPTH-1:0] id_src1;
  logic [REG_FILE_DEPTH-1:0] id_src2;
  logic                      exe_wb_en;
  logic [REG_FILE_DEPTH-1:0] exe_dst;
  logic                      exe_mem_read;
  logic                      mem_wb_en;
  logic [REG_FILE_DEPTH-1:0] mem_dst;
  logic                      branch_taken;
  logic                      mem_req;
  logic                      sram_ready;

  logic                      freeze_pc;
  logic                      freeze_if_id;
  logic                      bubble_id;
  logic                      flush_if_id;
  logic                      flush_id_ex;
  logic                      freeze_all;
  logic                      mem_timeout;
  logic [CNT_WIDTH-1:0]      stall_cycles;

  modport master (
    output id_has_src1, id_has_src2, id_src1, id_src2,
           exe_wb_en, exe_dst, exe_mem_read, mem_wb_en, mem_dst,
           branch_taken, mem_req, sram_ready,
    input  freeze_pc, freeze_if_id, bubble_id, flush_if_id, flush_id_ex,
           freeze_all, mem_timeout, stall_cycles
  );

  modport slave (
    input  id_has_src1, id_has_src2, id_src1, id_src2,
           exe_wb_en, exe_dst, exe_mem_read, mem_wb_en, mem_dst,
           branch_taken, mem_req, sram_ready,
    output freeze_pc, freeze_if_id, bubble_id, flush_if_id, flush_id_ex,
           freeze_all, mem_timeout, stall_cycles
  );

endinterface

// File: rtl/hazard_stall_controller_raw_hazard_detect.sv
// Combinational RAW hazard between the ID sources and EXE/MEM destinations.
//   FORWARD_EN=1 : only a load in EXE feeding ID is a hazard (load-use)
//   FORWARD_EN=0 : any EXE or MEM writeback feeding ID is a hazard
//   hz           : ID must stall this cycle
module raw_hazard_detect
  import hazard_stall_controller_pkg::*;
#(
  parameter int FORWARD_EN = 1
) (
  input  logic                      id_has_src1,
  input  logic                      id_has_src2,
  input  logic [REG_FILE_DEPTH-1:0] id_src1,
  input  logic [REG_FILE_DEPTH-1:0] id_src2,
  input  logic                      exe_wb_en,
  input  logic [REG_FILE_DEPTH-1:0] exe_dst,
  input  logic                      exe_mem_read,
  input  logic                      mem_wb_en,
  input  logic [REG_FILE_DEPTH-1:0] mem_dst,
  output logic                      hz
);

  logic exe_match;
  logic mem_match;

  assign exe_match = (id_has_src1 && (id_src1 == exe_dst)) ||
                     (id_has_src2 && (id_src2 == exe_dst));
  assign mem_match = (id_has_src1 && (id_src1 == mem_dst)) ||
                     (id_has_src2 && (id_src2 == mem_dst));

  assign hz = (FORWARD_EN != 0) ? (exe_wb_en && exe_mem_read && exe_match)
                                : ((exe_wb_en && exe_match) || (mem_wb_en && mem_match));

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline freeze/bubble/flush sequencer with memory-wait timeout and a
// saturating stall-cycle counter.
//   clk, rst : clock, synchronous active-low reset
//   bus      : slave side of hazard_stall_controller_if
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int FORWARD_EN  = 1,
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int CNT_WIDTH   = 16
) (
  input logic                      clk,
  input logic                      rst,
  hazard_stall_controller_if.slave bus
);

  localparam int WAIT_W = 16;

  state_t               state, state_nxt;
  logic [WAIT_W-1:0]    wait_cnt, wait_cnt_nxt;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic                 hz;
  logic                 mem_stall;
  logic                 timeout_hit;
  logic                 act;
  logic                 freeze_pc, freeze_if_id, bubble_id;
  logic                 flush_if_id, flush_id_ex, freeze_all, mem_timeout;

  raw_hazard_detect #(.FORWARD_EN(FORWARD_EN)) u_raw_hazard_detect (
    .id_has_src1  (bus.id_has_src1),
    .id_has_src2  (bus.id_has_src2),
    .id_src1      (bus.id_src1),
    .id_src2      (bus.id_src2),
    .exe_wb_en    (bus.exe_wb_en),
    .exe_dst      (bus.exe_dst),
    .exe_mem_read (bus.exe_mem_read),
    .mem_wb_en    (bus.mem_wb_en),
    .mem_dst      (bus.mem_dst),
    .hz           (hz)
  );

  assign mem_stall   = bus.mem_req && !bus.sram_ready;
  assign timeout_hit = (wait_cnt == WAIT_W'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // A completing access wins over the timeout when both land on the same cycle.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (bus.sram_ready || timeout_hit) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // act: memory is not holding the pipeline, so branch/hazard rules apply.
  always_comb begin
    act          = 1'b0;
    freeze_pc    = 1'b0;
    freeze_if_id = 1'b0;
    bubble_id    = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    freeze_all   = 1'b0;
    mem_timeout  = 1'b0;
    if (rst) begin
      case (state)
        RUN: begin
          if (mem_stall) freeze_all = 1'b1;
          else           act        = 1'b1;
        end
        MEM_WAIT: begin
          if (bus.sram_ready)  act         = 1'b1;
          else if (timeout_hit) mem_timeout = 1'b1;
          else                  freeze_all  = 1'b1;
        end
        default: act = 1'b0;
      endcase
      if (act) begin
        if (bus.branch_taken) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (hz) begin
          freeze_pc    = 1'b1;
          freeze_if_id = 1'b1;
          bubble_id    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if ((freeze_all || bubble_id) && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end

  assign bus.freeze_pc    = freeze_pc;
  assign bus.freeze_if_id = freeze_if_id;
  assign bus.bubble_id    = bubble_id;
  assign bus.flush_if_id  = flush_if_id;
  assign bus.flush_id_ex  = flush_id_ex;
  assign bus.freeze_all   = freeze_all;
  assign bus.mem_timeout  = mem_timeout;
  assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller. Instance A: forwarding present, default
// timeout, 16-bit counter. Instance B: no forwarding, timeout 3, 3-bit counter.
module tb_hazard_stall_controller;

  // output vector: {freeze_pc, freeze_if_id, bubble_id, flush_if_id, flush_id_ex, freeze_all, mem_timeout}
  localparam logic [6:0] E_NONE  = 7'b000_0000;
  localparam logic [6:0] E_HZ    = 7'b111_0000;
  localparam logic [6:0] E_FLUSH = 7'b000_1100;
  localparam logic [6:0] E_FRZ   = 7'b000_0010;
  localparam logic [6:0] E_TO    = 7'b000_0001;
  localparam int         CAP_A   = 65535;
  localparam int         CAP_B   = 7;

  typedef struct packed {
    logic       has1;
    logic [3:0] src1;
    logic       has2;
    logic [3:0] src2;
    logic       exe_wb;
    logic       exe_rd;
    logic [3:0] exe_dst;
    logic       mem_wb;
    logic [3:0] mem_dst;
    logic       br;
    logic       req;
    logic       rdy;
  } stim_t;

  logic clk;
  logic rst_a, rst_b;
  int   tests_run, tests_failed;
  int   exp_stall_a, exp_stall_b;
  logic [6:0] exp_q[$];
  logic [6:0] obs_a, obs_b;

  hazard_stall_controller_if #(.CNT_WIDTH(16)) ifa ();
  hazard_stall_controller_if #(.CNT_WIDTH(3))  ifb ();

  hazard_stall_controller #(.FORWARD_EN(1), .MEM_TIMEOUT(255), .CNT_WIDTH(16)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa)
  );

  hazard_stall_controller #(.FORWARD_EN(0), .MEM_TIMEOUT(3), .CNT_WIDTH(3)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb)
  );

  assign obs_a = {ifa.freeze_pc, ifa.freeze_if_id, ifa.bubble_id, ifa.flush_if_id,
                  ifa.flush_id_ex, ifa.freeze_all, ifa.mem_timeout};
  assign obs_b = {ifb.freeze_pc, ifb.freeze_if_id, ifb.bubble_id, ifb.flush_if_id,
                  ifb.flush_id_ex, ifb.freeze_all, ifb.mem_timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(input logic has1, input logic [3:0] src1,
                               input logic has2, input logic [3:0] src2,
                               input logic exe_wb, input logic exe_rd, input logic [3:0] exe_dst,
                               input logic mem_wb, input logic [3:0] mem_dst,
                               input logic br, input logic req, input logic rdy);
    stim_t s;
    s.has1 = has1; s.src1 = src1; s.has2 = has2; s.src2 = src2;
    s.exe_wb = exe_wb; s.exe_rd = exe_rd; s.exe_dst = exe_dst;
    s.mem_wb = mem_wb; s.mem_dst = mem_dst;
    s.br = br; s.req = req; s.rdy = rdy;
    return s;
  endfunction

  task automatic drive(input bit sel_b, input stim_t s);
    if (!sel_b) begin
      ifa.id_has_src1 = s.has1; ifa.id_src1 = s.src1;
      ifa.id_has_src2 = s.has2; ifa.id_src2 = s.src2;
      ifa.exe_wb_en = s.exe_wb; ifa.exe_mem_read = s.exe_rd; ifa.exe_dst = s.exe_dst;
      ifa.mem_wb_en = s.mem_wb; ifa.mem_dst = s.mem_dst;
      ifa.branch_taken = s.br; ifa.mem_req = s.req; ifa.sram_ready = s.rdy;
    end else begin
      ifb.id_has_src1 = s.has1; ifb.id_src1 = s.src1;
      ifb.id_has_src2 = s.has2; ifb.id_src2 = s.src2;
      ifb.exe_wb_en = s.exe_wb; ifb.exe_mem_read = s.exe_rd; ifb.exe_dst = s.exe_dst;
      ifb.mem_wb_en = s.mem_wb; ifb.mem_dst = s.mem_dst;
      ifb.branch_taken = s.br; ifb.mem_req = s.req; ifb.sram_ready = s.rdy;
    end
  endtask

  // Drive a table into instance A, comparing each cycle against the scoreboard.
  task automatic run_a(input string name, input stim_t s[], input logic [6:0] e[]);
    logic [6:0] want;
    for (int i = 0; i < s.size(); i++) begin
      @(posedge clk); #2;
      drive(1'b0, s[i]);
      exp_q.push_back(e[i]);
      if ((e[i][1] || e[i][4]) && exp_stall_a < CAP_A) exp_stall_a++;
      #4;
      want = exp_q.pop_front();
      tests_run++;
      if (obs_a !== want) begin
        tests_failed++;
        $display("FAIL %s[%0d] outputs got %b want %b", name, i, obs_a, want);
      end
    end
    @(posedge clk); #1;
    drive(1'b0, mk(0,0,0,0, 0,0,0, 0,0, 0,0,0));
    tests_run++;
    if (ifa.stall_cycles !== 16'(exp_stall_a)) begin
      tests_failed++;
      $display("FAIL %s stall_cycles got %0d want %0d", name, ifa.stall_cycles, exp_stall_a);
    end
  endtask

  task automatic run_b(input string name, input stim_t s[], input logic [6:0] e[]);
    logic [6:0] want;
    for (int i = 0; i < s.size(); i++) begin
      @(posedge clk); #2;
      drive(1'b1, s[i]);
      exp_q.push_back(e[i]);
      if ((e[i][1] || e[i][4]) && exp_stall_b < CAP_B) exp_stall_b++;
      #4;
      want = exp_q.pop_front();
      tests_run++;
      if (obs_b !== want) begin
        tests_failed++;
        $display("FAIL %s[%0d] outputs got %b want %b", name, i, obs_b, want);
      end
    end
    @(posedge clk); #1;
    drive(1'b1, mk(0,0,0,0, 0,0,0, 0,0, 0,0,0));
    tests_run++;
    if (ifb.stall_cycles !== 3'(exp_stall_b)) begin
      tests_failed++;
      $display("FAIL %s stall_cycles got %0d want %0d", name, ifb.stall_cycles, exp_stall_b);
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b0;
    rst_b = 1'b0;
    // Hazard on A and memory stall on B, both must be masked by reset.
    drive(1'b0, mk(1,3,0,0, 1,1,3, 0,0, 1,0,0));
    drive(1'b1, mk(0,0,0,0, 0,0,0, 0,0, 0,1,0));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #3;
      tests_run += 4;
      if (obs_a !== E_NONE) begin
        tests_failed++; $display("FAIL reset_outputs_a got %b want %b", obs_a, E_NONE);
      end
      if (obs_b !== E_NONE) begin
        tests_failed++; $display("FAIL reset_outputs_b got %b want %b", obs_b, E_NONE);
      end
      if (ifa.stall_cycles !== 16'd0) begin
        tests_failed++; $display("FAIL reset_stall_a got %0d want 0", ifa.stall_cycles);
      end
      if (ifb.stall_cycles !== 3'd0) begin
        tests_failed++; $display("FAIL reset_stall_b got %0d want 0", ifb.stall_cycles);
      end
    end
    drive(1'b0, mk(0,0,0,0, 0,0,0, 0,0, 0,0,0));
    drive(1'b1, mk(0,0,0,0, 0,0,0, 0,0, 0,0,0));
    rst_a = 1'b1;
    rst_b = 1'b1;
    exp_stall_a = 0;
    exp_stall_b = 0;
  endtask

  task automatic test_load_use();
    stim_t s[] = new[4];
    logic [6:0] e[] = new[4];
    s[0] = mk(1,3,0,0, 1,1,3, 0,0, 0,0,0); e[0] = E_HZ;    // LDR R3 in EXE, ADD uses R3
    s[1] = mk(1,3,0,0, 0,0,0, 1,3, 0,0,0); e[1] = E_NONE;  // load moved to MEM, forwarded
    s[2] = mk(1,3,0,0, 1,0,3, 0,0, 0,0,0); e[2] = E_NONE;  // non-load producer, forwarded
    s[3] = mk(0,0,1,9, 1,1,9, 0,0, 0,0,0); e[3] = E_HZ;    // load-use via src2
    run_a("load_use", s, e);
  endtask

  task automatic test_no_forward();
    stim_t s[] = new[4];
    logic [6:0] e[] = new[4];
    s[0] = mk(0,0,1,5, 0,0,0, 1,5, 0,0,0); e[0] = E_HZ;
    s[1] = mk(0,0,0,5, 0,0,0, 1,5, 0,0,0); e[1] = E_NONE;  // src2 not read
    s[2] = mk(1,7,0,0, 1,0,7, 0,0, 0,0,0); e[2] = E_HZ;    // ALU producer in EXE
    s[3] = mk(1,7,0,0, 0,0,7, 0,0, 0,0,0); e[3] = E_NONE;  // EXE does not write back
    run_b("no_forward", s, e);
  endtask

  task automatic test_branch_flush();
    stim_t s[] = new[2];
    logic [6:0] e[] = new[2];
    s[0] = mk(1,3,0,0, 1,1,3, 0,0, 1,0,0); e[0] = E_FLUSH;
    s[1] = mk(0,0,0,0, 0,0,0, 0,0, 1,0,0); e[1] = E_FLUSH;
    run_a("branch_flush", s, e);
  endtask

  task automatic test_mem_wait();
    stim_t s[] = new[10];
    logic [6:0] e[] = new[10];
    s[0] = mk(0,0,0,0, 0,0,0, 0,0, 0,1,0); e[0] = E_FRZ;
    s[1] = mk(0,0,0,0, 0,0,0, 0,0, 0,1,0); e[1] = E_FRZ;
    s[2] = mk(0,0,0,0, 0,0,0, 0,0, 0,1,0); e[2] = E_FRZ;
    s[3] = mk(0,0,0,0, 0,0,0, 0,0, 0,1,0); e[3] = E_FRZ;
    s[4] = mk(0,0,0,0, 0,0,0, 0,0, 0,1,1); e[4] = E_NONE;  // ready
    s[5] = mk(0,0,0,0, 0,0,0, 0,0, 0,0,0); e[5] = E_NONE;  // back in RUN
    s[6] = mk(1,3,0,0, 1,1,3, 0,0, 1,1,0); e[6] = E_FRZ;   // freeze beats branch and hazard
    s[7] = mk(1,3,0,0, 1,1,3, 0,0, 1,1,1); e[7] = E_FLUSH; // held branch acted on at ready
    s[8] = mk(0,0,0,0, 0,0,0, 0,0, 0,1,1); e[8] = E_NONE;  // zero-wait access
    s[9] = mk(0,0,0,0, 0,0,0, 0,0, 0,0,0); e[9] = E_NONE;
    run_a("mem_wait", s, e);
  endtask

  task automatic test_timeout();
    stim_t s[] = new[5];
    logic [6:0] e[] = new[5];
    s[0] = mk(0,0,0,0, 0,0,0, 0,0, 0,1,0); e[0] = E_FRZ;   // enter MEM_WAIT
    s[1] = mk(0,0,0,0, 0,0,0, 0,0, 0,0,0); e[1] = E_FRZ;   // wait 1
    s[2] = mk(0,0,0,0, 0,0,0, 0,0, 0,0,0); e[2] = E_FRZ;   // wait 2
    s[3] = mk(0,0,0,0, 0,0,0, 0,0, 0,0,0); e[3] = E_TO;    // wait 3 == limit
    s[4] = mk(0,0,0,0, 0,0,0, 0,0, 0,0,0); e[4] = E_NONE;  // RUN again
    run_b("timeout", s, e);
  endtask

  task automatic test_reset_mid_wait();
    stim_t s[] = new[4];
    logic [6:0] e[] = new[4];
    logic [6:0] want;
    @(posedge clk); #2;
    drive(1'b1, mk(0,0,0,0, 0,0,0, 0,0, 0,1,0));
    exp_q.push_back(E_FRZ);
    #4;
    want = exp_q.pop_front();
    tests_run++;
    if (obs_b !== want) begin
      tests_failed++; $display("FAIL rst_wait_enter got %b want %b", obs_b, want);
    end
    @(posedge clk); #2;
    drive(1'b1, mk(0,0,0,0, 0,0,0, 0,0, 0,0,0));
    rst_b = 1'b0;
    exp_q.push_back(E_NONE);
    #4;
    want = exp_q.pop_front();
    tests_run++;
    if (obs_b !== want) begin
      tests_failed++; $display("FAIL rst_wait_mask got %b want %b", obs_b, want);
    end
    @(posedge clk); #1;
    rst_b = 1'b1;
    exp_stall_b = 0;
    tests_run++;
    if (ifb.stall_cycles !== 3'd0) begin
      tests_failed++; $display("FAIL rst_wait_stall got %0d want 0", ifb.stall_cycles);
    end
    for (int i = 0; i < 4; i++) begin
      s[i] = mk(0,0,0,0, 0,0,0, 0,0, 0,0,0);
      e[i] = E_NONE;
    end
    run_b("rst_wait_after", s, e);
  endtask

  task automatic test_saturation();
    stim_t s[] = new[10];
    logic [6:0] e[] = new[10];
    for (int i = 0; i < 10; i++) begin
      s[i] = mk(0,0,1,5, 0,0,0, 1,5, 0,0,0);
      e[i] = E_HZ;
    end
    run_b("saturation", s, e);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_stall_a  = 0;
    exp_stall_b  = 0;
    test_reset();
    test_load_use();
    test_no_forward();
    test_branch_flush();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
